// File: rtl/float_pkg.sv
// Shared constants and helpers for the float-to-integer converter.
package float_pkg;

  // Operand class decided in the unpack stage.
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,  // exp == 0: zero or subnormal, always flushed
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fclass_e;

  // Exponent bias for an exponent field of the given width.
  function automatic int exp_bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction

  // Bit position of the sign within a packed {sign, exp, man} word.
  function automatic int sign_pos(input int exp_width, input int man_width);
    return exp_width + man_width;
  endfunction

  // LSB position of the exponent field within a packed word.
  function automatic int exp_lsb(input int man_width);
    return man_width;
  endfunction

  // Largest positive signed value, 2^(w-1)-1, zero-extended to 128 bits.
  function automatic logic [127:0] sat_pos(input int int_width);
    return (128'd1 << (int_width - 1)) - 128'd1;
  endfunction

  // Most negative signed value, -2^(w-1), as a w-bit pattern in 128 bits.
  function automatic logic [127:0] sat_neg(input int int_width);
    return 128'd1 << (int_width - 1);
  endfunction

  // Classify from pre-decoded field tests.
  function automatic fclass_e classify(input logic exp_zero, input logic exp_ones,
                                       input logic man_zero);
    fclass_e cls;
    if (exp_zero) begin
      cls = CLS_ZERO;
    end else if (exp_ones) begin
      cls = man_zero ? CLS_INF : CLS_NAN;
    end else begin
      cls = CLS_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/float_to_int_shift.sv
// Bidirectional significand shifter: scales sig by 2^(e - MAN_WIDTH) into an
// INT_WIDTH magnitude, and reports whether any set bits fell off the right end.
// Shift distances are clamped, so any exponent value gives a defined result;
// results outside 0 <= e < INT_WIDTH are ignored by the caller.
module float_to_int_shift #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int INT_WIDTH = 32
) (
  input  logic [MAN_WIDTH:0]        sig,
  input  logic signed [EXP_WIDTH:0] e,
  output logic [INT_WIDTH-1:0]      mag,
  output logic                      sticky
);

  localparam int SigW = MAN_WIDTH + 1;

  logic [2*SigW-1:0] right_vec;
  int                e_int;
  int                lamt;
  int                ramt;

  // Pick left or right shift from the sign of (e - MAN_WIDTH).
  always_comb begin
    e_int     = int'(e);
    lamt      = 0;
    ramt      = 0;
    right_vec = '0;
    mag       = '0;
    sticky    = 1'b0;
    if (e_int >= MAN_WIDTH) begin
      lamt = e_int - MAN_WIDTH;
      if (lamt > INT_WIDTH) begin
        lamt = INT_WIDTH;
      end
      mag = INT_WIDTH'(sig) << lamt;
    end else begin
      // Lower half of right_vec catches the bits shifted out.
      ramt = MAN_WIDTH - e_int;
      if (ramt > SigW) begin
        ramt = SigW;
      end
      right_vec = {sig, {SigW{1'b0}}} >> ramt;
      mag       = INT_WIDTH'(right_vec[2*SigW-1:SigW]);
      sticky    = |right_vec[SigW-1:0];
    end
  end

endmodule

// File: rtl/float_to_int_conv.sv
// Two-stage float to signed integer converter with valid/ready stream ports.
// S1 unpacks and classifies; S2 shifts, applies sign, saturates and flags.
// Rounding is toward zero.
module float_to_int_conv
  import float_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int INT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INT_WIDTH-1:0]           out_data,
  output logic                           out_overflow,
  output logic                           out_inexact,
  output logic                           out_invalid
);

  localparam int SignPos = sign_pos(EXP_WIDTH, MAN_WIDTH);
  localparam int ExpLsb  = exp_lsb(MAN_WIDTH);

  localparam logic [EXP_WIDTH:0]   Bias   = (EXP_WIDTH + 1)'(exp_bias(EXP_WIDTH));
  localparam logic [INT_WIDTH-1:0] SatPos = INT_WIDTH'(sat_pos(INT_WIDTH));
  localparam logic [INT_WIDTH-1:0] SatNeg = INT_WIDTH'(sat_neg(INT_WIDTH));

  // Handshake
  logic s2_adv;
  logic s1_adv;

  // Input field decode
  logic                    in_sign;
  logic [EXP_WIDTH-1:0]    in_exp;
  logic [MAN_WIDTH-1:0]    in_man;
  logic signed [EXP_WIDTH:0] in_e;
  fclass_e                 in_cls;

  // S1 registers
  logic                      s1_valid;
  logic                      s1_sign;
  logic signed [EXP_WIDTH:0] s1_e;
  logic [MAN_WIDTH-1:0]      s1_man;
  fclass_e                   s1_cls;

  // S2 next-state
  logic [MAN_WIDTH:0]   s1_sig;
  logic [INT_WIDTH-1:0] sh_mag;
  logic                 sh_sticky;
  logic [INT_WIDTH-1:0] nxt_data;
  logic                 nxt_ovf;
  logic                 nxt_inx;
  logic                 nxt_inv;
  int                   e_int;

  // S2 register: out_valid/out_data/flags are the stage outputs directly.
  logic s2_valid;

  assign out_valid = s2_valid;

  // Stage advance: a stage may load when empty or when its contents leave.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
  end

  // Unpack and classify the incoming word.
  always_comb begin
    in_sign = in_data[SignPos];
    in_exp  = in_data[ExpLsb +: EXP_WIDTH];
    in_man  = in_data[MAN_WIDTH-1:0];
    in_e    = $signed({1'b0, in_exp} - Bias);
    in_cls  = classify((in_exp == '0), (&in_exp), (in_man == '0));
  end

  // S1 pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_e     <= '0;
      s1_man   <= '0;
      s1_cls   <= CLS_ZERO;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_e    <= in_e;
        s1_man  <= in_man;
        s1_cls  <= in_cls;
      end
    end
  end

  assign s1_sig = {1'b1, s1_man};

  float_to_int_shift #(
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH),
    .INT_WIDTH (INT_WIDTH)
  ) u_shift (
    .sig    (s1_sig),
    .e      (s1_e),
    .mag    (sh_mag),
    .sticky (sh_sticky)
  );

  // Resolve result and flags from class, exponent range and shifter output.
  always_comb begin
    e_int    = int'(s1_e);
    nxt_data = '0;
    nxt_ovf  = 1'b0;
    nxt_inx  = 1'b0;
    nxt_inv  = 1'b0;
    case (s1_cls)
      CLS_NAN: begin
        nxt_inv = 1'b1;
      end
      CLS_INF: begin
        nxt_data = s1_sign ? SatNeg : SatPos;
        nxt_ovf  = 1'b1;
      end
      CLS_ZERO: begin
        // Subnormals flush to zero; only the discarded fraction is reported.
        nxt_inx = (s1_man != '0);
      end
      default: begin
        if (e_int < 0) begin
          nxt_inx = 1'b1;
        end else if (e_int >= INT_WIDTH - 1) begin
          nxt_data = s1_sign ? SatNeg : SatPos;
          // -2^(INT_WIDTH-1) itself is representable.
          nxt_ovf  = !(s1_sign && (e_int == INT_WIDTH - 1) && (s1_man == '0));
        end else begin
          nxt_data = s1_sign ? -sh_mag : sh_mag;
          nxt_inx  = sh_sticky;
        end
      end
    endcase
  end

  // S2 pipeline register; holds its contents while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_inexact  <= 1'b0;
      out_invalid  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= nxt_data;
        out_overflow <= nxt_ovf;
        out_inexact  <= nxt_inx;
        out_invalid  <= nxt_inv;
      end
    end
  end

endmodule

// File: doc/float_to_int_conv.md
Name: float_to_int_conv

Overview:
- Pipelined floating-point to signed-integer converter. It is the inverse of the int-to-float normalize path, which uses leading-zero counting to build floats.
- Unpacks an IEEE-style float, classifies it, then shifts the significand into a two's-complement integer.
- Rounding is toward zero, with saturation and status flags.
- Sits on the matmul result path and drives integer consumers with a valid/ready stream.

Parameters:
- EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1.
- MAN_WIDTH, 23, stored mantissa width (hidden bit implicit).
- INT_WIDTH, 32, signed output width; must be >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  converter can accept a word this cycle.
- in_data  input  1+EXP_WIDTH+MAN_WIDTH  {sign, exp, man}.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  INT_WIDTH  signed result.
- out_overflow  output  1  value outside the representable range, or infinity; result saturated.
- out_inexact  output  1  nonzero fraction bits discarded.
- out_invalid  output  1  input was NaN.

Behaviour:
- Reset is asynchronous, active-high. While rst is high, all valid bits clear: out_valid=0, in_ready=1, out_data=0, all flags 0. Asserting rst mid-operation discards in-flight words; no partial output is produced.
- Pipeline has 2 stages: S1 (unpack/classify), S2 (shift/saturate). Latency is 2 cycles from input handshake to out_valid with no stall. Throughput is 1 word/cycle.
- Handshake:
  - Transfer occurs when valid&&ready.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances. in_ready must not depend on in_valid.
  - out_data and flags are held stable while out_valid && !out_ready.
- S1 computes:
  - e = exp - bias, signed, EXP_WIDTH+1 bits.
  - significand sig = {1, man}, MAN_WIDTH+1 bits.
  - class: ZERO/SUBNORMAL (exp==0), INF (exp all-ones, man==0), NAN (exp all-ones, man!=0), NORMAL.
- S2 rules, by class:
  - NAN: out_data=0, invalid=1, other flags 0.
  - INF: saturate by sign, overflow=1.
  - exp==0: out_data=0; inexact=(man!=0). Subnormals are flushed. Negative zero gives 0.
  - NORMAL with e<0: out_data=0, inexact=1.
  - NORMAL with e>=INT_WIDTH-1: overflow=1, saturate. Exception: sign=1, e==INT_WIDTH-1, man==0 gives exactly -2^(INT_WIDTH-1), no flags.
  - Otherwise:
    - mag = e>=MAN_WIDTH ? sig<<(e-MAN_WIDTH) : sig>>(MAN_WIDTH-e).
    - inexact = OR of bits shifted out.
    - out_data = sign ? -mag : mag.
- Saturation values: positive gives 2^(INT_WIDTH-1)-1; negative gives -2^(INT_WIDTH-1).
- Flags are mutually exclusive except inexact, which is 0 whenever overflow or invalid is set.
- Widths: internal magnitude is INT_WIDTH bits; shift distance is clamped before shifting, so no X/overflow occurs for any exponent value.

Decomposition:
- float_pkg holds:
  - bias function of EXP_WIDTH;
  - field slice offsets;
  - the 2-bit class enum constants (CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN);
  - the saturation constants as functions of INT_WIDTH.
- One sub-module, float_to_int_shift: a combinational bidirectional shifter producing mag and a sticky (inexact) bit from sig and e, instantiated in S2.
- The handshake and pipeline registers stay in float_to_int_conv.

Test Plan (defaults 8/23/32):
- 0x40490FDB (3.14159) -> out_data=3, inexact=1, out_valid 2 cycles after accept.
- 0xC2F60000 (-123.0) -> 0xFFFFFF85, no flags; 0x3F000000 (0.5) -> 0, inexact=1.
- 0x4F000000 (2^31) -> 0x7FFFFFFF, overflow=1; 0xCF000000 (-2^31) -> 0x80000000, no flags; 0xFF800000 (-inf) -> 0x80000000, overflow=1.
- 0x7FC00000 (NaN) -> 0, invalid=1; 0x80000000 (-0) -> 0, no flags; 0x00000001 (subnormal) -> 0, inexact=1.
- Back-to-back stream of 8 words with out_ready toggling 1,0,0,1 -> all 8 results in order, none lost or duplicated, outputs stable during stall, in_ready low only while both stages are full and stalled.
- Assert rst with 2 words in flight -> out_valid=0 immediately (asynchronous), no stale result after release, next accepted word emerges after 2 cycles.
